ad_ip_jesd204_tpl_up_arbiter: RTL and testbench



---
 rtl/ad_ip_jesd204_tpl_up_arbiter_if.sv | 48 ++++
 rtl/ad_ip_jesd204_tpl_up_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_up_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_ip_jesd204_tpl_up_arbiter_if.sv
// ad_ip_jesd204_tpl_up_arbiter_if
// Requester-side and register-slave-side up_* bus around the TPL arbiter.
interface ad_ip_jesd204_tpl_up_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 11
);
  logic [NUM_MASTERS-1:0]            m_wreq;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_waddr;
  logic [NUM_MASTERS*32-1:0]         m_wdata;
  logic [NUM_MASTERS-1:0]            m_wack;
  logic [NUM_MASTERS-1:0]            m_rreq;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_raddr;
  logic [NUM_MASTERS*32-1:0]         m_rdata;
  logic [NUM_MASTERS-1:0]            m_rack;

  logic                              up_wreq;
  logic [ADDR_WIDTH-1:0]             up_waddr;
  logic [31:0]                       up_wdata;
  logic                              up_wack;
  logic                              up_rreq;
  logic [ADDR_WIDTH-1:0]             up_raddr;
  logic [31:0]                       up_rdata;
  logic                              up_rack;
  logic                              up_timeout;
  logic [7:0]                        up_timeout_cnt;

  // arbiter side
  modport slave (
    input  m_wreq, m_waddr, m_wdata,
    input  m_rreq, m_raddr,
    input  up_wack, up_rack, up_rdata,
    output m_wack, m_rack, m_rdata,
    output up_wreq, up_waddr, up_wdata,
    output up_rreq, up_raddr,
    output up_timeout, up_timeout_cnt
  );

  // requesters plus register slaves
  modport master (
    output m_wreq, m_waddr, m_wdata,
    output m_rreq, m_raddr,
    output up_wack, up_rack, up_rdata,
    input  m_wack, m_rack, m_rdata,
    input  up_wreq, up_waddr, up_wdata,
    input  up_rreq, up_raddr,
    input  up_timeout, up_timeout_cnt
  );
endinterface

// File: rtl/ad_ip_jesd204_tpl_up_arbiter.sv
// ad_ip_jesd204_tpl_up_arbiter
// Round-robin sharing of the TPL up_* register bus, one access in flight.
module ad_ip_jesd204_tpl_up_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 11,
  parameter int TIMEOUT     = 31
) (
  input  logic up_clk,
  input  logic up_rstn,
  ad_ip_jesd204_tpl_up_arbiter_if.slave bus
);
  localparam int N  = NUM_MASTERS;
  localparam int AW = ADDR_WIDTH;
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          wv_q, wv_d;
  logic [N-1:0]          rv_q, rv_d;
  logic [N-1:0][AW-1:0]  wa_q, wa_d;
  logic [N-1:0][AW-1:0]  ra_q, ra_d;
  logic [N-1:0][31:0]    wd_q, wd_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         own_q, own_d;
  logic                  is_wr_q, is_wr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            tcnt_q, tcnt_d;
  logic                  up_wreq_q, up_wreq_d;
  logic                  up_rreq_q, up_rreq_d;
  logic [AW-1:0]         up_waddr_q, up_waddr_d;
  logic [AW-1:0]         up_raddr_q, up_raddr_d;
  logic [31:0]           up_wdata_q, up_wdata_d;
  logic [N-1:0]          m_wack_q, m_wack_d;
  logic [N-1:0]          m_rack_q, m_rack_d;
  logic [N-1:0][31:0]    m_rdata_q, m_rdata_d;
  logic                  tout_q, tout_d;

  logic [IW:0]           grant;
  logic [IW-1:0]         sel;
  logic                  done;

  // first pending master after 'last', cyclically; MSB flags a hit
  function automatic logic [IW:0] pick(
    input logic [IW-1:0] last,
    input logic [N-1:0]  pend
  );
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!r[IW] && pend[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction

  // arbitration, completion and slot capture
  always_comb begin
    state_d    = state_q;
    wv_d       = wv_q;
    rv_d       = rv_q;
    wa_d       = wa_q;
    ra_d       = ra_q;
    wd_d       = wd_q;
    last_d     = last_q;
    own_d      = own_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    up_wreq_d  = 1'b0;
    up_rreq_d  = 1'b0;
    up_waddr_d = up_waddr_q;
    up_raddr_d = up_raddr_q;
    up_wdata_d = up_wdata_q;
    m_wack_d   = '0;
    m_rack_d   = '0;
    m_rdata_d  = '0;
    tout_d     = 1'b0;
    done       = 1'b0;
    grant      = pick(last_q, wv_q | rv_q);
    sel        = grant[IW-1:0];

    unique case (state_q)
      IDLE: begin
        if (grant[IW]) begin
          own_d   = sel;
          last_d  = sel;
          cnt_d   = 8'd0;
          state_d = WAIT;
          if (wv_q[sel]) begin
            is_wr_d    = 1'b1;
            up_wreq_d  = 1'b1;
            up_waddr_d = wa_q[sel];
            up_wdata_d = wd_q[sel];
          end else begin
            is_wr_d    = 1'b0;
            up_rreq_d  = 1'b1;
            up_raddr_d = ra_q[sel];
          end
        end
      end
      WAIT: begin
        done = is_wr_q ? bus.up_wack : bus.up_rack;
        if (done || cnt_q == 8'(TIMEOUT)) begin
          if (is_wr_q) begin
            m_wack_d[own_q] = 1'b1;
            wv_d[own_q]     = 1'b0;
          end else begin
            m_rack_d[own_q]  = 1'b1;
            m_rdata_d[own_q] = done ? bus.up_rdata
                                    : 32'hDEAD_DEAD;
            rv_d[own_q]      = 1'b0;
          end
          if (!done) begin
            tout_d = 1'b1;
            if (tcnt_q != 8'hff) tcnt_d = tcnt_q + 8'd1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // a pulse into a busy slot is dropped; a freed slot takes it
    for (int i = 0; i < N; i++) begin
      if (bus.m_wreq[i] && !wv_d[i]) begin
        wv_d[i] = 1'b1;
        wa_d[i] = bus.m_waddr[i*AW +: AW];
        wd_d[i] = bus.m_wdata[i*32 +: 32];
      end
      if (bus.m_rreq[i] && !rv_d[i]) begin
        rv_d[i] = 1'b1;
        ra_d[i] = bus.m_raddr[i*AW +: AW];
      end
    end
  end

  // state and output registers
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q    <= IDLE;
      wv_q       <= '0;
      rv_q       <= '0;
      wa_q       <= '0;
      ra_q       <= '0;
      wd_q       <= '0;
      last_q     <= IW'(N - 1);
      own_q      <= '0;
      is_wr_q    <= 1'b0;
      cnt_q      <= 8'd0;
      tcnt_q     <= 8'd0;
      up_wreq_q  <= 1'b0;
      up_rreq_q  <= 1'b0;
      up_waddr_q <= '0;
      up_raddr_q <= '0;
      up_wdata_q <= '0;
      m_wack_q   <= '0;
      m_rack_q   <= '0;
      m_rdata_q  <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wv_q       <= wv_d;
      rv_q       <= rv_d;
      wa_q       <= wa_d;
      ra_q       <= ra_d;
      wd_q       <= wd_d;
      last_q     <= last_d;
      own_q      <= own_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      up_wreq_q  <= up_wreq_d;
      up_rreq_q  <= up_rreq_d;
      up_waddr_q <= up_waddr_d;
      up_raddr_q <= up_raddr_d;
      up_wdata_q <= up_wdata_d;
      m_wack_q   <= m_wack_d;
      m_rack_q   <= m_rack_d;
      m_rdata_q  <= m_rdata_d;
      tout_q     <= tout_d;
    end
  end

  assign bus.up_wreq        = up_wreq_q;
  assign bus.up_rreq        = up_rreq_q;
  assign bus.up_waddr       = up_waddr_q;
  assign bus.up_raddr       = up_raddr_q;
  assign bus.up_wdata       = up_wdata_q;
  assign bus.m_wack         = m_wack_q;
  assign bus.m_rack         = m_rack_q;
  assign bus.m_rdata        = m_rdata_q;
  assign bus.up_timeout     = tout_q;
  assign bus.up_timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_up_arbiter.sv
// tb_ad_ip_jesd204_tpl_up_arbiter
// Transaction model plus directed scenarios for the up_* arbiter.
module tb_ad_ip_jesd204_tpl_up_arbiter;
  localparam int N  = 2;
  localparam int AW = 11;
  localparam int TO = 31;

  logic clk = 1'b0;
  logic up_rstn;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ad_ip_jesd204_tpl_up_arbiter_if #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW)
  ) bus ();

  ad_ip_jesd204_tpl_up_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .up_clk (clk),
    .up_rstn(up_rstn),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- event logs ----------------
  typedef struct {int c; int m; bit wr; bit to; logic [31:0] d;} ack_t;
  typedef struct {int c; bit wr; logic [31:0] a; logic [31:0] d;} sreq_t;
  ack_t  acks[$];
  sreq_t sreqs[$];

  // ---------------- transaction model ----------------
  bit                 pw[N], pr[N];
  logic [AW-1:0]      pwa[N], pra[N];
  logic [31:0]        pwd[N];
  bit                 busy, own_wr;
  int                 own, t_issue, last, tcnt;
  bit                 e_wreq, e_rreq, e_to;
  logic [AW-1:0]      e_waddr, e_raddr;
  logic [31:0]        e_wdata;
  logic [N-1:0]       e_wack, e_rack;
  logic [N*32-1:0]    e_rdata;
  logic [7:0]         e_tcnt;

  task automatic mdl_reset();
    for (int m = 0; m < N; m++) begin
      pw[m] = 0; pr[m] = 0; pwa[m] = '0; pra[m] = '0; pwd[m] = '0;
    end
    busy = 0; own_wr = 0; own = 0; t_issue = 0;
    last = N - 1; tcnt = 0;
    e_wreq = 0; e_rreq = 0; e_to = 0;
    e_waddr = '0; e_raddr = '0; e_wdata = '0;
    e_wack = '0; e_rack = '0; e_rdata = '0; e_tcnt = '0;
  endtask

  // outputs for the next cycle from this cycle's inputs
  task automatic mdl_step();
    bit got;
    e_wreq = 0; e_rreq = 0; e_to = 0;
    e_wack = '0; e_rack = '0; e_rdata = '0;
    if (busy) begin
      got = own_wr ? bus.up_wack : bus.up_rack;
      if (got || (cyc - t_issue) == TO) begin
        if (own_wr) begin
          e_wack[own] = 1'b1; pw[own] = 0;
        end else begin
          e_rack[own] = 1'b1; pr[own] = 0;
          e_rdata[own*32 +: 32] = got ? bus.up_rdata : 32'hDEAD_DEAD;
        end
        if (!got) begin
          e_to = 1;
          if (tcnt < 255) tcnt++;
        end
        busy = 0;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int m;
        m = (last + k) % N;
        if (!busy && (pw[m] || pr[m])) begin
          busy = 1; own = m; own_wr = pw[m];
          t_issue = cyc + 1; last = m;
          if (pw[m]) begin
            e_wreq = 1; e_waddr = pwa[m]; e_wdata = pwd[m];
          end else begin
            e_rreq = 1; e_raddr = pra[m];
          end
        end
      end
    end
    for (int m = 0; m < N; m++) begin
      if (bus.m_wreq[m] && !pw[m]) begin
        pw[m] = 1;
        pwa[m] = bus.m_waddr[m*AW +: AW];
        pwd[m] = bus.m_wdata[m*32 +: 32];
      end
      if (bus.m_rreq[m] && !pr[m]) begin
        pr[m] = 1;
        pra[m] = bus.m_raddr[m*AW +: AW];
      end
    end
    e_tcnt = 8'(tcnt);
  endtask

  // compare every cycle, log events, advance the model
  always @(negedge clk) begin
    if (!up_rstn) mdl_reset();
    chk("up_wreq", bus.up_wreq, e_wreq);
    chk("up_rreq", bus.up_rreq, e_rreq);
    chk("up_waddr", bus.up_waddr, e_waddr);
    chk("up_raddr", bus.up_raddr, e_raddr);
    chk("up_wdata", bus.up_wdata, e_wdata);
    chk("m_wack", bus.m_wack, e_wack);
    chk("m_rack", bus.m_rack, e_rack);
    chk("m_rdata", bus.m_rdata, e_rdata);
    chk("up_timeout", bus.up_timeout, e_to);
    chk("up_timeout_cnt", bus.up_timeout_cnt, e_tcnt);
    if (bus.up_wreq || bus.up_rreq)
      sreqs.push_back('{cyc, bus.up_wreq,
        32'(bus.up_wreq ? bus.up_waddr : bus.up_raddr), bus.up_wdata});
    for (int m = 0; m < N; m++)
      if (bus.m_wack[m] || bus.m_rack[m])
        acks.push_back('{cyc, m, bus.m_wack[m], bus.up_timeout,
                         bus.m_rdata[m*32 +: 32]});
    if (up_rstn) mdl_step();
  end

  // ---------------- register slave ----------------
  int          lat = 1;
  int          cd = 0;
  bit          swr;
  logic [31:0] sa;

  always @(posedge clk) begin
    #1;
    bus.up_wack = 0; bus.up_rack = 0; bus.up_rdata = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        if (swr) bus.up_wack = 1;
        else begin
          bus.up_rack = 1; bus.up_rdata = sa + 32'h100;
        end
      end
    end
    if (bus.up_wreq || bus.up_rreq) begin
      swr = bus.up_wreq;
      sa  = 32'(bus.up_wreq ? bus.up_waddr : bus.up_raddr);
      cd  = lat;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic waitn(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [N-1:0] w, input logic [N-1:0] r,
                       output int t);
    bus.m_wreq = w; bus.m_rreq = r; t = cyc;
    step();
    bus.m_wreq = '0; bus.m_rreq = '0;
  endtask

  task automatic clr_logs();
    acks.delete(); sreqs.delete();
  endtask

  int t, nm0;

  initial begin
    up_rstn = 1'b1;
    bus.m_wreq = '0; bus.m_rreq = '0;
    bus.m_waddr = '0; bus.m_raddr = '0; bus.m_wdata = '0;
    bus.up_wack = 0; bus.up_rack = 0; bus.up_rdata = '0;
    #1 up_rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 up_rstn = 1'b1;
    waitn(2);
    @(negedge clk);
    chk("rst_tcnt", bus.up_timeout_cnt, 0);
    chk("rst_wreq", bus.up_wreq, 0);
    step();

    // contention: both read, master 0 first
    clr_logs();
    bus.m_raddr[0*AW +: AW] = 11'h001;
    bus.m_raddr[1*AW +: AW] = 11'h002;
    pulse(2'b00, 2'b11, t);
    waitn(12);
    chk("cont_n", acks.size(), 2);
    chk("cont_m0", acks[0].m, 0);
    chk("cont_d0", acks[0].d, 32'h101);
    chk("cont_c0", acks[0].c, t + 4);
    chk("cont_m1", acks[1].m, 1);
    chk("cont_d1", acks[1].d, 32'h102);
    chk("cont_c1", acks[1].c, t + 7);
    chk("cont_serial", sreqs[1].c > acks[0].c, 1);

    // single write from master 0
    clr_logs();
    bus.m_waddr[0*AW +: AW] = 11'h010;
    bus.m_wdata[0*32 +: 32] = 32'hA5A5_0001;
    pulse(2'b01, 2'b00, t);
    waitn(8);
    chk("wr_sreq_c", sreqs[0].c, t + 2);
    chk("wr_sreq_a", sreqs[0].a, 32'h010);
    chk("wr_sreq_d", sreqs[0].d, 32'hA5A5_0001);
    chk("wr_ack_c", acks[0].c, t + 4);
    chk("wr_ack_wr", acks[0].wr, 1);
    chk("wr_ack_to", acks[0].to, 0);

    // fairness: both masters keep re-requesting writes
    clr_logs();
    bus.m_waddr[0*AW +: AW] = 11'h020;
    bus.m_waddr[1*AW +: AW] = 11'h021;
    bus.m_wdata = {32'h1111_0001, 32'h0000_0000};
    for (int g = 0; g < 200 && acks.size() < 8; g++) begin
      bus.m_wreq = 2'b11;
      step();
    end
    bus.m_wreq = '0;
    waitn(20);
    chk("fair_budget", acks.size() >= 8, 1);
    nm0 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("fair_order", acks[i].m, (i + 1) % 2);
      if (acks[i].m == 0) nm0++;
    end
    chk("fair_m0_cnt", nm0, 4);

    // write and read from master 1 in one cycle
    clr_logs();
    bus.m_waddr[1*AW +: AW] = 11'h030;
    bus.m_wdata[1*32 +: 32] = 32'h1234_5678;
    bus.m_raddr[1*AW +: AW] = 11'h031;
    pulse(2'b10, 2'b10, t);
    waitn(10);
    chk("wr_rd_s0_wr", sreqs[0].wr, 1);
    chk("wr_rd_s0_c", sreqs[0].c, t + 2);
    chk("wr_rd_s1_wr", sreqs[1].wr, 0);
    chk("wr_rd_s1_c", sreqs[1].c, t + 5);
    chk("wr_rd_a0_c", acks[0].c, t + 4);
    chk("wr_rd_a1_c", acks[1].c, t + 7);
    chk("wr_rd_a1_d", acks[1].d, 32'h131);

    // timeout on a read, then a normal write
    clr_logs();
    lat = 0;
    bus.m_raddr[0*AW +: AW] = 11'h055;
    pulse(2'b00, 2'b01, t);
    waitn(40);
    chk("to_c", acks[0].c, t + 2 + TO + 1);
    chk("to_d", acks[0].d, 32'hDEAD_DEAD);
    chk("to_pulse", acks[0].to, 1);
    chk("to_cnt", bus.up_timeout_cnt, 1);
    lat = 1;
    bus.m_waddr[1*AW +: AW] = 11'h040;
    pulse(2'b10, 2'b00, t);
    waitn(8);
    chk("to_next_c", acks[1].c, t + 4);
    chk("to_next_to", acks[1].to, 0);
    chk("to_cnt_hold", bus.up_timeout_cnt, 1);

    // reset in the middle of a read, slave acks after release
    clr_logs();
    lat = 6;
    bus.m_raddr[0*AW +: AW] = 11'h077;
    pulse(2'b00, 2'b01, t);
    waitn(3);
    up_rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_tcnt", bus.up_timeout_cnt, 0);
    chk("rst_mid_rack", bus.m_rack, 0);
    waitn(2);
    up_rstn = 1'b1;
    waitn(8);
    chk("rst_no_ack", acks.size(), 0);
    chk("rst_sreq_n", sreqs.size(), 1);
    lat = 1;
    bus.m_waddr[0*AW +: AW] = 11'h050;
    bus.m_waddr[1*AW +: AW] = 11'h051;
    pulse(2'b11, 2'b00, t);
    waitn(10);
    chk("rst_cont_m0", acks[0].m, 0);
    chk("rst_cont_m1", acks[1].m, 1);

    waitn(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
